// File: rtl/divider.sv
// RV32M divide unit: DIV/DIVU/REM/REMU, one restoring step per cycle.
// Result is held in DONE until the pipeline acknowledges it.
module divider #(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic        i_clk_n,
    input  logic        i_rst,
    input  logic [31:0] i_in_a,
    input  logic [31:0] i_in_b,
    input  logic [2:0]  i_funct3,
    input  logic        i_div_en,
    input  logic        i_ack,
    output logic [31:0] o_result,
    output logic        o_busy
);

    generate
        if (DIV_BITS_PER_CYCLE != 1) begin : g_bad_radix
            $error("divider: only DIV_BITS_PER_CYCLE == 1 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic        sel_rem;
    logic        sgn_a;
    logic        sgn_b;

    logic        req;
    logic        op_signed;
    logic        b_zero;
    logic        ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign req       = i_div_en & i_funct3[2];
    assign op_signed = ~i_funct3[0];
    assign b_zero    = (i_in_b == 32'd0);
    assign ovf       = op_signed && (i_in_a == 32'h8000_0000) &&
                       (i_in_b == 32'hFFFF_FFFF);
    assign abs_a     = (op_signed && i_in_a[31]) ? -i_in_a : i_in_a;
    assign abs_b     = (op_signed && i_in_b[31]) ? -i_in_b : i_in_b;

    // quo doubles as the dividend shift register: its MSB feeds the remainder.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] q_step;
    logic [31:0] r_step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvsr};
    assign ge      = ~diff[32];
    assign q_step  = {quo[30:0], ge};
    assign r_step  = ge ? diff[31:0] : shifted[31:0];
    assign q_fix   = (sgn_a ^ sgn_b) ? -q_step : q_step;
    assign r_fix   = sgn_a ? -r_step : r_step;

    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_result  = 32'd0;
        unique case (state)
            IDLE: begin
                o_busy = req;
                if (req) begin
                    state_nxt = (b_zero || ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                o_busy = 1'b1;
                if (cnt == 5'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_result = sel_rem ? rem : quo;
                if (i_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            cnt     <= 5'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dvsr    <= 32'd0;
            sel_rem <= 1'b0;
            sgn_a   <= 1'b0;
            sgn_b   <= 1'b0;
        end else if (state == IDLE && req) begin
            sel_rem <= i_funct3[1];
            sgn_a   <= op_signed & i_in_a[31];
            sgn_b   <= op_signed & i_in_b[31];
            dvsr    <= abs_b;
            cnt     <= 5'd31;
            if (b_zero) begin
                quo <= 32'hFFFF_FFFF;
                rem <= i_in_a;
            end else if (ovf) begin
                quo <= 32'h8000_0000;
                rem <= 32'd0;
            end else begin
                quo <= abs_a;
                rem <= 32'd0;
            end
        end else if (state == CALC) begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) begin
                quo <= q_fix;
                rem <= r_fix;
            end else begin
                quo <= q_step;
                rem <= r_step;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: vector table plus hold, ignore
// and mid-operation reset sequences.
module tb_divider;

    logic        i_clk_n = 1'b0;
    logic        i_rst;
    logic [31:0] i_in_a;
    logic [31:0] i_in_b;
    logic [2:0]  i_funct3;
    logic        i_div_en;
    logic        i_ack;
    logic [31:0] o_result;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;

    divider #(.DIV_BITS_PER_CYCLE(1)) dut (
        .i_clk_n (i_clk_n),
        .i_rst   (i_rst),
        .i_in_a  (i_in_a),
        .i_in_b  (i_in_b),
        .i_funct3(i_funct3),
        .i_div_en(i_div_en),
        .i_ack   (i_ack),
        .o_result(o_result),
        .o_busy  (o_busy)
    );

    always #5 i_clk_n = ~i_clk_n;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          busy;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue at a negedge, count busy cycles, check result, then ack.
    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_busy);
        int cycles;
        @(negedge i_clk_n);
        i_in_a   = a;
        i_in_b   = b;
        i_funct3 = f3;
        i_div_en = 1'b1;
        i_ack    = 1'b0;
        cycles   = 0;
        #1;
        while (o_busy && cycles < 100) begin
            cycles++;
            @(negedge i_clk_n);
        end
        chk({name, " busy"}, 32'(cycles), 32'(exp_busy));
        chk({name, " result"}, o_result, exp);
        i_div_en = 1'b0;
        i_ack    = 1'b1;
        @(negedge i_clk_n);
        i_ack = 1'b0;
        chk({name, " idle result"}, o_result, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"divu 100/7",  F_DIVU, 32'd100, 32'd7, 32'd14, 33};
        vecs[1]  = '{"remu 100/7",  F_REMU, 32'd100, 32'd7, 32'd2, 33};
        vecs[2]  = '{"div -7/2",    F_DIV, 32'hFFFF_FFF9, 32'd2,
                     32'hFFFF_FFFD, 33};
        vecs[3]  = '{"rem -7/2",    F_REM, 32'hFFFF_FFF9, 32'd2,
                     32'hFFFF_FFFF, 33};
        vecs[4]  = '{"div x/0",     F_DIV, 32'h1234_5678, 32'd0,
                     32'hFFFF_FFFF, 1};
        vecs[5]  = '{"rem x/0",     F_REM, 32'h1234_5678, 32'd0,
                     32'h1234_5678, 1};
        vecs[6]  = '{"div ovf",     F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 1};
        vecs[7]  = '{"rem ovf",     F_REM, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'd0, 1};
        vecs[8]  = '{"divu big",    F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'd0, 33};
        vecs[9]  = '{"remu big",    F_REMU, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 33};
        vecs[10] = '{"div 7/-2",    F_DIV, 32'd7, 32'hFFFF_FFFE,
                     32'hFFFF_FFFD, 33};
        vecs[11] = '{"rem 7/-2",    F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33};
        vecs[12] = '{"div -100/-7", F_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                     32'd14, 33};
        vecs[13] = '{"rem -100/-7", F_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                     32'hFFFF_FFFE, 33};
        vecs[14] = '{"divu max/1",  F_DIVU, 32'hFFFF_FFFF, 32'd1,
                     32'hFFFF_FFFF, 33};
        vecs[15] = '{"remu max/16", F_REMU, 32'hFFFF_FFFF, 32'd16,
                     32'd15, 33};

        i_rst    = 1'b1;
        i_in_a   = '0;
        i_in_b   = '0;
        i_funct3 = '0;
        i_div_en = 1'b0;
        i_ack    = 1'b0;
        repeat (2) @(posedge i_clk_n);
        @(negedge i_clk_n);
        i_rst = 1'b0;
        chk("reset result", o_result, 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].busy);
        end

        // Non-divide funct3 must be ignored.
        @(negedge i_clk_n);
        i_funct3 = 3'b011;
        i_div_en = 1'b1;
        #1;
        chk("ignore busy", 32'(o_busy), 32'd0);
        repeat (3) @(negedge i_clk_n);
        chk("ignore result", o_result, 32'd0);
        chk("ignore busy later", 32'(o_busy), 32'd0);
        i_div_en = 1'b0;

        // Held instruction in DONE, operands scrambled during CALC.
        @(negedge i_clk_n);
        i_in_a   = 32'd100;
        i_in_b   = 32'd7;
        i_funct3 = F_DIVU;
        i_div_en = 1'b1;
        i_ack    = 1'b1;
        @(negedge i_clk_n);
        i_in_a = 32'hDEAD_BEEF;
        i_in_b = 32'd3;
        begin
            int cyc = 0;
            while (o_busy && cyc < 100) begin
                cyc++;
                @(negedge i_clk_n);
            end
            chk("hold calc len", 32'(cyc), 32'd32);
        end
        i_ack = 1'b0;
        @(negedge i_clk_n);
        chk("hold enter", o_result, 32'd14);
        repeat (5) begin
            @(negedge i_clk_n);
            chk("hold result", o_result, 32'd14);
            chk("hold busy", 32'(o_busy), 32'd0);
        end
        i_ack    = 1'b1;
        i_div_en = 1'b0;
        @(negedge i_clk_n);
        i_ack = 1'b0;
        chk("hold release", o_result, 32'd0);
        chk("hold release busy", 32'(o_busy), 32'd0);

        // Reset in the middle of CALC aborts the operation.
        @(negedge i_clk_n);
        i_in_a   = 32'd1000;
        i_in_b   = 32'd3;
        i_funct3 = F_DIVU;
        i_div_en = 1'b1;
        repeat (11) @(negedge i_clk_n);
        chk("calc busy", 32'(o_busy), 32'd1);
        i_div_en = 1'b0;
        i_rst    = 1'b1;
        @(negedge i_clk_n);
        i_rst = 1'b0;
        chk("abort result", o_result, 32'd0);
        chk("abort busy", 32'(o_busy), 32'd0);
        repeat (40) @(negedge i_clk_n);
        chk("abort stays idle", o_result, 32'd0);
        run_op("divu 9/3", F_DIVU, 32'd9, 32'd3, 32'd3, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
